// File: rtl/alu_req_arbiter_pkg.sv
// Shared ALU definitions for the request arbiter: opcode encodings, FSM state
// encodings and opcode classification helpers.
package alu_req_arbiter_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] alu_op_t;

  localparam alu_op_t OP_ADD    = 3'b000;
  localparam alu_op_t OP_SUB    = 3'b001;
  localparam alu_op_t OP_MUL    = 3'b010;
  localparam alu_op_t OP_PASSA  = 3'b011;
  localparam alu_op_t OP_PASSB  = 3'b100;
  localparam alu_op_t OP_CLEAR  = 3'b101;
  localparam alu_op_t OP_FINISH = 3'b110;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_EXEC = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP = 2'd2;

  // Anything above CLEAR (FINISH and the unused code) is never sent to the ALU.
  function automatic logic op_legal(input alu_op_t op);
    return (op <= OP_CLEAR);
  endfunction

  // Only ADD/SUB produce a meaningful zero indication.
  function automatic logic op_sets_zero(input alu_op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_req_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after the rotating
// pointer and moves the pointer past the winner on each advance strobe.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt_onehot
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] nxt_ptr;
  logic [IDX_W:0]   sum;
  logic             found;

  // Scan requesters starting at the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    sum        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= NUM_REQ_W) begin
        sum = sum - NUM_REQ_W;
      end
      if (!found && req[sum[IDX_W-1:0]]) begin
        found                       = 1'b1;
        win_idx                     = sum[IDX_W-1:0];
        gnt_onehot[sum[IDX_W-1:0]]  = 1'b1;
      end
    end
  end

  always_comb begin
    if (win_idx == LAST_IDX) begin
      nxt_ptr = '0;
    end else begin
      nxt_ptr = win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= nxt_ptr;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NUM_REQ requesters: round-robin grant, registered issue
// onto the ALU inputs, result capture and a one-cycle response pulse to the winner.
module alu_req_arbiter
  import alu_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_LEN    = 16,
  parameter int ALU_SIG_LEN = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*ALU_SIG_LEN-1:0] req_op,
  input  logic [NUM_REQ*DATA_LEN-1:0]    req_a,
  input  logic [NUM_REQ*DATA_LEN-1:0]    req_b,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_LEN-1:0]            rsp_data,
  output logic                           rsp_zero,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [DATA_LEN-1:0]            alu_a,
  output logic [DATA_LEN-1:0]            alu_b,
  output logic [ALU_SIG_LEN-1:0]         alu_select,
  input  logic [DATA_LEN-1:0]            alu_out
);

  localparam logic [ALU_SIG_LEN-1:0] SEL_CLEAR = ALU_SIG_LEN'(OP_CLEAR);

  logic [ST_W-1:0]        state;
  logic [NUM_REQ-1:0]     win_onehot;
  logic                   any_req;
  logic                   advance;
  logic [ALU_SIG_LEN-1:0] op_sel;
  logic [DATA_LEN-1:0]    a_sel;
  logic [DATA_LEN-1:0]    b_sel;
  logic                   op_ok;
  logic [NUM_REQ-1:0]     owner_p0;
  logic                   err_p0;
  logic                   res_zero;

  assign any_req = |req;
  assign advance = (state == ST_IDLE) && any_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .advance    (advance),
    .gnt_onehot (win_onehot)
  );

  // Operand mux driven by the one-hot winner.
  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_onehot[i]) begin
        op_sel = req_op[i*ALU_SIG_LEN +: ALU_SIG_LEN];
        a_sel  = req_a[i*DATA_LEN +: DATA_LEN];
        b_sel  = req_b[i*DATA_LEN +: DATA_LEN];
      end
    end
    op_ok = op_legal(alu_op_t'(op_sel));
  end

  // alu z_flag is stale for non-add/sub ops, so zero is derived from alu_out here.
  assign res_zero = !err_p0 && op_sets_zero(alu_op_t'(alu_select)) && (alu_out == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= SEL_CLEAR;
      owner_p0   <= '0;
      err_p0     <= 1'b0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      case (state)
        // IDLE -> EXEC: grant the winner and issue its operands to the ALU
        ST_IDLE: begin
          if (any_req) begin
            gnt        <= win_onehot;
            owner_p0   <= win_onehot;
            alu_a      <= a_sel;
            alu_b      <= b_sel;
            alu_select <= op_ok ? op_sel : SEL_CLEAR;
            err_p0     <= !op_ok;
            busy       <= 1'b1;
            state      <= ST_EXEC;
          end
        end
        // EXEC -> RESP: capture the result; park select on CLEAR so the next
        // issue always changes select and forces the ALU to re-evaluate
        ST_EXEC: begin
          rsp_valid  <= owner_p0;
          rsp_data   <= err_p0 ? '0 : alu_out;
          rsp_zero   <= res_zero;
          rsp_err    <= err_p0;
          alu_select <= SEL_CLEAR;
          state      <= ST_RESP;
        end
        // RESP -> IDLE: recovery cycle, requests ignored
        ST_RESP: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Randomized bench for alu_req_arbiter with a transaction-level reference model
// and a behavioural ALU that only re-evaluates on A/select changes.
module tb_alu_req_arbiter;

  localparam int N  = 2;
  localparam int DW = 16;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*SW-1:0] req_op;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N-1:0]  gnt;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero;
  logic          rsp_err;
  logic          busy;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [SW-1:0] alu_select;
  logic [DW-1:0] alu_out;

  always #5 clk = ~clk;

  alu_req_arbiter #(
    .NUM_REQ     (N),
    .DATA_LEN    (DW),
    .ALU_SIG_LEN (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_out    (alu_out)
  );

  function automatic logic [DW-1:0] alu_fn(input logic [2:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return a;
      3'd4:    return b;
      default: return '0;
    endcase
  endfunction

  // External ALU: insensitive to B on purpose.
  always @(alu_a or alu_select) alu_out = alu_fn(alu_select, alu_a, alu_b);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester state
  logic          pend [N];
  logic [2:0]    r_op [N];
  logic [DW-1:0] r_a  [N];
  logic [DW-1:0] r_b  [N];

  // Reference model state
  int            s;
  int            free_at;
  int            rr;
  int            gnt_step;
  logic          rsp_pend;
  int            rsp_step;
  int            rsp_idx;
  logic [DW-1:0] exp_data;
  logic          exp_zero;
  logic          exp_err;

  logic [DW-1:0] last_data;
  logic          last_zero;
  logic          last_err;
  int            gnt_hist [$];

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req[i]                = pend[i];
      req_op[i*SW +: SW]    = r_op[i];
      req_a[i*DW +: DW]     = r_a[i];
      req_b[i*DW +: DW]     = r_b[i];
    end
  endtask

  task automatic load(input int i, input logic [2:0] op, input logic [DW-1:0] a,
                      input logic [DW-1:0] b);
    pend[i] = 1'b1;
    r_op[i] = op;
    r_a[i]  = a;
    r_b[i]  = b;
  endtask

  task automatic load_rand(input int i);
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    a = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
    case ($urandom_range(0, 3))
      0:       b = a;
      1:       b = 16'd0 - a;
      default: b = 16'($urandom);
    endcase
    load(i, 3'($urandom_range(0, 7)), a, b);
  endtask

  task automatic step(input logic reload);
    logic [N-1:0]  exp_gnt;
    logic [N-1:0]  exp_v;
    logic [2:0]    op;
    logic          legal;
    logic [DW-1:0] ia;
    logic [DW-1:0] ib;
    int            w;
    drive();
    exp_gnt = '0;
    w       = -1;
    op      = '0;
    legal   = 1'b0;
    ia      = '0;
    ib      = '0;
    if (s >= free_at) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (rr + k) % N;
        if (w < 0 && pend[c]) w = c;
      end
    end
    if (w >= 0) begin
      exp_gnt[w] = 1'b1;
      rr         = (w + 1) % N;
      free_at    = s + 3;
      gnt_step   = s;
      op         = r_op[w];
      ia         = r_a[w];
      ib         = r_b[w];
      legal      = (op <= 3'd5);
      exp_data   = legal ? alu_fn(op, ia, ib) : '0;
      exp_zero   = (op == 3'd0 || op == 3'd1) && (exp_data == '0);
      exp_err    = !legal;
      rsp_pend   = 1'b1;
      rsp_step   = s + 1;
      rsp_idx    = w;
    end
    @(posedge clk);
    #1;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("busy", 32'(busy), ((s - gnt_step) <= 1) ? 32'd1 : 32'd0);
    if (gnt != '0) gnt_hist.push_back(int'(gnt));
    if (w >= 0) begin
      chk("issue_a", 32'(alu_a), 32'(ia));
      chk("issue_b", 32'(alu_b), 32'(ib));
      chk("issue_sel", 32'(alu_select), legal ? 32'(op) : 32'd5);
    end
    exp_v = '0;
    if (rsp_pend && rsp_step == s) begin
      exp_v[rsp_idx] = 1'b1;
      chk("rsp_data", 32'(rsp_data), 32'(exp_data));
      chk("rsp_zero", 32'(rsp_zero), 32'(exp_zero));
      chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("sel_clear", 32'(alu_select), 32'd5);
      rsp_pend = 1'b0;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (rsp_valid != '0) begin
      last_data = rsp_data;
      last_zero = rsp_zero;
      last_err  = rsp_err;
    end
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        pend[i] = 1'b0;
        if (reload) load_rand(i);
      end
    end
    s++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_b", 32'(alu_b), 32'd0);
      chk("rst_alu_sel", 32'(alu_select), 32'd5);
    end
    rst      = 1'b0;
    rr       = 0;
    rsp_pend = 1'b0;
    s        = 0;
    free_at  = 0;
    gnt_step = -10;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    last_data = '0;
    last_zero = 1'b0;
    last_err  = 1'b0;
    exp_data  = '0;
    exp_zero  = 1'b0;
    exp_err   = 1'b0;
    rsp_step  = 0;
    rsp_idx   = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      r_op[i] = '0;
      r_a[i]  = '0;
      r_b[i]  = '0;
    end

    do_reset(2);

    // Single ADD
    load(0, 3'd0, 16'd5, 16'd7);
    repeat (3) step(1'b0);
    chk("add_data", 32'(last_data), 32'd12);
    chk("add_zero", 32'(last_zero), 32'd0);

    // SUB to zero, then truncated MUL
    load(1, 3'd1, 16'd9, 16'd9);
    repeat (3) step(1'b0);
    chk("sub_data", 32'(last_data), 32'd0);
    chk("sub_zero", 32'(last_zero), 32'd1);
    load(1, 3'd2, 16'd300, 16'd300);
    repeat (3) step(1'b0);
    chk("mul_data", 32'(last_data), 32'h5F90);
    chk("mul_zero", 32'(last_zero), 32'd0);

    // Contention: both held high, grants must alternate every 3 cycles
    gnt_hist.delete();
    load_rand(0);
    load_rand(1);
    repeat (12) step(1'b1);
    chk("contention_count", 32'(gnt_hist.size()), 32'd4);
    for (int k = 0; k < gnt_hist.size(); k++) begin
      chk("contention_order", 32'(gnt_hist[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    repeat (3) step(1'b0);

    // Back-to-back identical PASSB with only B changing
    load(0, 3'd4, 16'd0, 16'd3);
    repeat (3) step(1'b0);
    chk("passb_first", 32'(last_data), 32'd3);
    load(0, 3'd4, 16'd0, 16'd8);
    repeat (3) step(1'b0);
    chk("passb_second", 32'(last_data), 32'd8);

    // Illegal opcode
    load(0, 3'd6, 16'd1, 16'd2);
    repeat (3) step(1'b0);
    chk("illegal_err", 32'(last_err), 32'd1);
    chk("illegal_data", 32'(last_data), 32'd0);

    // Abort: reset while in EXEC, then pointer must be back at requester 0
    load(0, 3'd0, 16'd5, 16'd7);
    step(1'b0);
    do_reset(1);
    gnt_hist.delete();
    load(0, 3'd3, 16'd11, 16'd0);
    load(1, 3'd3, 16'd22, 16'd0);
    repeat (3) step(1'b0);
    chk("abort_rr_first", (gnt_hist.size() > 0) ? 32'(gnt_hist[0]) : 32'hdead, 32'd1);
    repeat (3) step(1'b0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) load_rand(i);
      end
      step(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    repeat (4) step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
